// File: rtl/pipe_ctrl.sv
// Pipeline controller for the 3-stage core. Arbitrates redirect, multi-cycle hold,
// load-use and debug-halt requests into per-stage hold/flush controls and a PC redirect.
// Also keeps a stall-cycle counter and a sticky multi-cycle timeout flag.
module pipe_ctrl #(
  parameter int unsigned MC_TIMEOUT = 64,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             jump_en_i,
  input  logic [31:0]      jump_addr_i,
  input  logic             hold_flag_i,
  input  logic             mc_done_i,
  input  logic             load_use_i,
  input  logic             halt_req_i,
  output logic             jump_en_o,
  output logic [31:0]      jump_addr_o,
  output logic             hold_pc_o,
  output logic             hold_if_id_o,
  output logic             hold_id_ex_o,
  output logic             flush_if_id_o,
  output logic             flush_id_ex_o,
  output logic             halt_ack_o,
  output logic             mc_err_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int unsigned McW = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [McW-1:0] McLast = McW'(MC_TIMEOUT - 1);

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StMcWait = 2'd1,
    StHalt   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [McW-1:0]   mc_cnt_q, mc_cnt_d;
  logic             mc_err_q, mc_err_d;
  logic             halt_ack_q, halt_ack_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign jump_addr_o = jump_addr_i;
  assign halt_ack_o  = halt_ack_q;
  assign mc_err_o    = mc_err_q;
  assign state_o     = state_q;
  assign stall_cnt_o = stall_cnt_q;

  // Next-state and combinational pipeline controls; reset forces a flushed, frozen front end.
  always_comb begin
    state_d       = state_q;
    mc_cnt_d      = mc_cnt_q;
    mc_err_d      = mc_err_q;
    jump_en_o     = 1'b0;
    hold_pc_o     = 1'b0;
    hold_if_id_o  = 1'b0;
    hold_id_ex_o  = 1'b0;
    flush_if_id_o = 1'b0;
    flush_id_ex_o = 1'b0;

    unique case (state_q)
      StRun: begin
        if (jump_en_i) begin
          jump_en_o     = 1'b1;
          flush_if_id_o = 1'b1;
          flush_id_ex_o = 1'b1;
        end else if (hold_flag_i) begin
          hold_pc_o    = 1'b1;
          hold_if_id_o = 1'b1;
          hold_id_ex_o = 1'b1;
          mc_cnt_d     = '0;
          state_d      = StMcWait;
        end else if (load_use_i) begin
          // One bubble: freeze fetch/decode, inject NOP into execute.
          hold_pc_o     = 1'b1;
          hold_if_id_o  = 1'b1;
          flush_id_ex_o = 1'b1;
        end else if (halt_req_i) begin
          hold_pc_o     = 1'b1;
          flush_if_id_o = 1'b1;
          state_d       = StHalt;
        end
      end
      StMcWait: begin
        if (mc_done_i) begin
          state_d = StRun;
        end else if (mc_cnt_q == McLast) begin
          // Abort the stuck unit and resume; remember the event.
          mc_err_d = 1'b1;
          state_d  = StRun;
        end else begin
          hold_pc_o    = 1'b1;
          hold_if_id_o = 1'b1;
          hold_id_ex_o = 1'b1;
          mc_cnt_d     = mc_cnt_q + 1'b1;
        end
      end
      StHalt: begin
        hold_pc_o     = 1'b1;
        hold_if_id_o  = 1'b1;
        flush_id_ex_o = 1'b1;
        if (!halt_req_i) begin
          state_d = StRun;
        end
      end
      default: begin
        state_d = StRun;
      end
    endcase

    if (rst) begin
      jump_en_o     = 1'b0;
      hold_pc_o     = 1'b1;
      hold_if_id_o  = 1'b0;
      hold_id_ex_o  = 1'b0;
      flush_if_id_o = 1'b1;
      flush_id_ex_o = 1'b1;
    end

    halt_ack_d  = (state_d == StHalt);
    stall_cnt_d = stall_cnt_q + CNT_W'(hold_pc_o);
  end

  // State register with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRun;
      mc_cnt_q    <= '0;
      mc_err_q    <= 1'b0;
      halt_ack_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mc_cnt_q    <= mc_cnt_d;
      mc_err_q    <= mc_err_d;
      halt_ack_q  <= halt_ack_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: inputs change on the falling edge, outputs are checked 1 ns later.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_en_i, hold_flag_i, mc_done_i, load_use_i, halt_req_i;
  logic [31:0] jump_addr_i;
  logic        jump_en_o, hold_pc_o, hold_if_id_o, hold_id_ex_o, flush_if_id_o, flush_id_ex_o;
  logic        halt_ack_o, mc_err_o;
  logic [31:0] jump_addr_o;
  logic [1:0]  state_o;
  logic [31:0] stall_cnt_o;
  logic [5:0]  ctrl;

  int n_cmp = 0;
  int n_bad = 0;

  // {jump, hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex}
  assign ctrl = {jump_en_o, hold_pc_o, hold_if_id_o, hold_id_ex_o, flush_if_id_o, flush_id_ex_o};

  always #5 clk = ~clk;

  pipe_ctrl #(.MC_TIMEOUT(8), .CNT_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .jump_en_i     (jump_en_i),
    .jump_addr_i   (jump_addr_i),
    .hold_flag_i   (hold_flag_i),
    .mc_done_i     (mc_done_i),
    .load_use_i    (load_use_i),
    .halt_req_i    (halt_req_i),
    .jump_en_o     (jump_en_o),
    .jump_addr_o   (jump_addr_o),
    .hold_pc_o     (hold_pc_o),
    .hold_if_id_o  (hold_if_id_o),
    .hold_id_ex_o  (hold_id_ex_o),
    .flush_if_id_o (flush_if_id_o),
    .flush_id_ex_o (flush_id_ex_o),
    .halt_ack_o    (halt_ack_o),
    .mc_err_o      (mc_err_o),
    .state_o       (state_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  task automatic drive(input logic j, input logic [31:0] a, input logic hf, input logic dn,
                       input logic lu, input logic hr);
    @(negedge clk);
    jump_en_i   = j;
    jump_addr_i = a;
    hold_flag_i = hf;
    mc_done_i   = dn;
    load_use_i  = lu;
    halt_req_i  = hr;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    jump_en_i = 0; jump_addr_i = '0; hold_flag_i = 0; mc_done_i = 0; load_use_i = 0;
    halt_req_i = 0;
    #12;
    n_cmp++;
    if (ctrl !== 6'b010011) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want %b", ctrl, 6'b010011);
    end
    n_cmp++;
    if ({state_o, halt_ack_o, mc_err_o} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_regs: got %b want 0000", {state_o, halt_ack_o, mc_err_o});
    end
    n_cmp++;
    if (stall_cnt_o !== 32'd0) begin
      n_bad++; $display("FAIL reset_stall: got %0d want 0", stall_cnt_o);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (ctrl !== 6'b000000) begin
      n_bad++; $display("FAIL reset_release_ctrl: got %b want 000000", ctrl);
    end
  endtask

  task automatic test_jump;
    drive(1, 32'h100, 1, 0, 1, 1);
    n_cmp++;
    if (ctrl !== 6'b100011) begin
      n_bad++; $display("FAIL jump_ctrl: got %b want 100011", ctrl);
    end
    n_cmp++;
    if (jump_addr_o !== 32'h100) begin
      n_bad++; $display("FAIL jump_addr: got %h want 00000100", jump_addr_o);
    end
    drive(0, 32'h0, 0, 0, 0, 0);
    n_cmp++;
    if ({state_o, ctrl} !== 8'b00_000000) begin
      n_bad++; $display("FAIL jump_after: got %b want 00000000", {state_o, ctrl});
    end
    n_cmp++;
    if (stall_cnt_o !== 32'd0) begin
      n_bad++; $display("FAIL jump_stall: got %0d want 0", stall_cnt_o);
    end
  endtask

  task automatic test_multicycle;
    drive(0, 0, 1, 0, 0, 0);
    n_cmp++;
    if ({state_o, ctrl} !== 8'b00_011100) begin
      n_bad++; $display("FAIL mc_start: got %b want 00011100", {state_o, ctrl});
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      n_cmp++;
      if ({state_o, ctrl} !== 8'b01_011100) begin
        n_bad++; $display("FAIL mc_wait%0d: got %b want 01011100", i, {state_o, ctrl});
      end
    end
    drive(0, 0, 0, 1, 0, 0);
    n_cmp++;
    if ({state_o, ctrl} !== 8'b01_000000) begin
      n_bad++; $display("FAIL mc_done: got %b want 01000000", {state_o, ctrl});
    end
    drive(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if ({state_o, mc_err_o} !== 3'b000) begin
      n_bad++; $display("FAIL mc_return: got %b want 000", {state_o, mc_err_o});
    end
    n_cmp++;
    if (stall_cnt_o !== 32'd4) begin
      n_bad++; $display("FAIL mc_stall: got %0d want 4", stall_cnt_o);
    end
  endtask

  task automatic test_load_use;
    drive(0, 0, 0, 0, 1, 0);
    n_cmp++;
    if ({state_o, ctrl} !== 8'b00_011001) begin
      n_bad++; $display("FAIL lu_bubble: got %b want 00011001", {state_o, ctrl});
    end
    drive(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if ({state_o, ctrl} !== 8'b00_000000) begin
      n_bad++; $display("FAIL lu_after: got %b want 00000000", {state_o, ctrl});
    end
    n_cmp++;
    if (stall_cnt_o !== 32'd5) begin
      n_bad++; $display("FAIL lu_stall: got %0d want 5", stall_cnt_o);
    end
  endtask

  task automatic test_timeout;
    drive(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      n_cmp++;
      if ({state_o, ctrl} !== 8'b01_011100) begin
        n_bad++; $display("FAIL to_wait%0d: got %b want 01011100", i, {state_o, ctrl});
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if ({state_o, ctrl, mc_err_o} !== 9'b01_000000_0) begin
      n_bad++; $display("FAIL to_abort: got %b want 010000000", {state_o, ctrl, mc_err_o});
    end
    drive(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if ({state_o, mc_err_o} !== 3'b001) begin
      n_bad++; $display("FAIL to_err: got %b want 001", {state_o, mc_err_o});
    end
    n_cmp++;
    if (stall_cnt_o !== 32'd13) begin
      n_bad++; $display("FAIL to_stall: got %0d want 13", stall_cnt_o);
    end
    drive(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (mc_err_o !== 1'b1) begin
      n_bad++; $display("FAIL to_sticky: got %b want 1", mc_err_o);
    end
  endtask

  task automatic test_halt_defer;
    drive(0, 0, 1, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1);
    n_cmp++;
    if ({state_o, ctrl, halt_ack_o} !== 9'b01_011100_0) begin
      n_bad++; $display("FAIL hd_wait: got %b want 010111000", {state_o, ctrl, halt_ack_o});
    end
    drive(0, 0, 0, 1, 0, 1);
    n_cmp++;
    if ({state_o, ctrl} !== 8'b01_000000) begin
      n_bad++; $display("FAIL hd_done: got %b want 01000000", {state_o, ctrl});
    end
    drive(0, 0, 0, 0, 0, 1);
    n_cmp++;
    if ({state_o, ctrl, halt_ack_o} !== 9'b00_010010_0) begin
      n_bad++; $display("FAIL hd_enter: got %b want 000100100", {state_o, ctrl, halt_ack_o});
    end
    drive(1, 32'h200, 0, 0, 0, 1);
    n_cmp++;
    if ({state_o, ctrl, halt_ack_o} !== 9'b10_011001_1) begin
      n_bad++; $display("FAIL hd_halted: got %b want 100110011", {state_o, ctrl, halt_ack_o});
    end
    drive(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if ({state_o, ctrl, halt_ack_o} !== 9'b10_011001_1) begin
      n_bad++; $display("FAIL hd_release: got %b want 100110011", {state_o, ctrl, halt_ack_o});
    end
    drive(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if ({state_o, ctrl, halt_ack_o} !== 9'b00_000000_0) begin
      n_bad++; $display("FAIL hd_resume: got %b want 000000000", {state_o, ctrl, halt_ack_o});
    end
    n_cmp++;
    if (stall_cnt_o !== 32'd18) begin
      n_bad++; $display("FAIL hd_stall: got %0d want 18", stall_cnt_o);
    end
  endtask

  task automatic test_reset_mid;
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if ({state_o, stall_cnt_o} !== {2'b01, 32'd19}) begin
      n_bad++; $display("FAIL rm_pre: got state %0d cnt %0d want 1 19", state_o, stall_cnt_o);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({state_o, mc_err_o, halt_ack_o} !== 4'b0000) begin
      n_bad++; $display("FAIL rm_regs: got %b want 0000", {state_o, mc_err_o, halt_ack_o});
    end
    n_cmp++;
    if (stall_cnt_o !== 32'd0) begin
      n_bad++; $display("FAIL rm_stall: got %0d want 0", stall_cnt_o);
    end
    n_cmp++;
    if (ctrl !== 6'b010011) begin
      n_bad++; $display("FAIL rm_ctrl: got %b want 010011", ctrl);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if ({state_o, ctrl, stall_cnt_o} !== {2'b00, 6'b000000, 32'd0}) begin
      n_bad++; $display("FAIL rm_after: got state %0d ctrl %b cnt %0d want 0 000000 0",
                        state_o, ctrl, stall_cnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_jump();
    test_multicycle();
    test_load_use();
    test_timeout();
    test_halt_defer();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
